// File: rtl/output_buffer_ctrl_pkg.sv
// Shared constants and state encodings for the output buffer controller.
//   ARRAY_ROW : systolic array row count; one result vector is ARRAY_ROW bytes
//   AXIS_W    : AXI-Stream beat width
//   gb_state_e: gearbox phase within a 96->64 vector pair
//   drain_state_e: drain FSM states
package output_buffer_ctrl_pkg;

    localparam int unsigned ARRAY_ROW = 12;
    localparam int unsigned AXIS_W    = 64;

    // Gb0: v0[63:0], Gb1: {v1[31:0], v0[95:64]}, Gb2: v1[95:32]
    typedef enum logic [1:0] {
        Gb0 = 2'd0,
        Gb1 = 2'd1,
        Gb2 = 2'd2
    } gb_state_e;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } drain_state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer with fully registered outputs and a
// registered upstream ready, so downstream tready never reaches the RAM read path.
//   clk, rst            : clock, synchronous active-high reset
//   in_data/valid/ready : upstream side
//   out_data/valid/ready: downstream side
module axis_skid_buffer #(
    parameter int unsigned W = 65
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] skid_data;
    logic         skid_vld;

    assign in_ready = ~skid_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            skid_data <= '0;
            skid_vld  <= 1'b0;
        end else if (out_ready || !out_valid) begin
            // Output register free this cycle: refill from skid first to keep order.
            if (skid_vld) begin
                out_data  <= skid_data;
                out_valid <= 1'b1;
                skid_vld  <= 1'b0;
            end else begin
                out_valid <= in_valid;
                if (in_valid) begin
                    out_data <= in_data;
                end
            end
        end else if (in_valid && in_ready) begin
            skid_data <= in_data;
            skid_vld  <= 1'b1;
        end
    end

endmodule

// File: rtl/output_buffer_ctrl.sv
// Ping-pong output buffer: the core fills the write bank one vector per cycle;
// a bank swap drains the filled bank through a 96->64 gearbox as an AXIS master.
//   clk, rst                : clock, synchronous active-high reset
//   i_wr_en, i_array_vec    : vector write into the write bank
//   i_bank_swap             : close write bank and start draining it
//   o_swap_ready            : no drain in progress
//   o_wr_overflow           : sticky, write attempted into a full bank
//   m_axis_*                : AXI-Stream master (tdata/tvalid/tready/tlast)
//   o_drain_done            : one-cycle pulse after the tlast handshake
module output_buffer_ctrl
    import output_buffer_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned VEC_W      = ARRAY_ROW * 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [VEC_W-1:0]  i_array_vec,
    input  logic              i_bank_swap,
    output logic              o_swap_ready,
    output logic              o_wr_overflow,
    output logic [AXIS_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              o_drain_done
);

    localparam int unsigned PtrW = DEPTH_LOG2 + 1;

    logic [VEC_W-1:0] ram [2**PtrW];

    drain_state_e state, state_next;
    gb_state_e    gb, gb_next;

    logic             bank_sel;
    logic [PtrW-1:0]  wr_ptr, drain_len, rd_ptr, vec_idx, new_len;
    logic             full, wr_accept, swap_accept, last_vec, tlast_hs;
    logic [VEC_W-1:0] rdata;
    logic             rdata_vld, rd_en, consume, lone;
    logic [31:0]      hold;
    logic [AXIS_W-1:0] beat_data;
    logic             beat_valid, beat_last, beat_accept, skid_ready;

    assign full        = wr_ptr[DEPTH_LOG2];
    assign wr_accept   = i_wr_en && !full;
    assign o_swap_ready = (state == StIdle);
    assign swap_accept = i_bank_swap && o_swap_ready;
    // A write coinciding with the swap still lands in the closing bank.
    assign new_len     = wr_ptr + PtrW'(wr_accept);
    assign last_vec    = (vec_idx == drain_len - PtrW'(1));
    assign tlast_hs    = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    assign beat_accept = beat_valid && skid_ready;
    // Refill the vector register only when it is empty or being released.
    assign rd_en = (state == StRun) && (rd_ptr != drain_len) && (!rdata_vld || consume);

    always_comb begin
        state_next = state;
        gb_next    = gb;
        beat_data  = '0;
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        consume    = 1'b0;

        unique case (state)
            StIdle: if (swap_accept && new_len != '0) state_next = StRun;
            StRun:  if (tlast_hs) state_next = StIdle;
            default: state_next = StIdle;
        endcase

        unique case (gb)
            Gb0: begin
                beat_valid = (state == StRun) && rdata_vld;
                beat_data  = rdata[63:0];
                if (beat_accept) begin
                    consume = 1'b1;
                    gb_next = Gb1;
                end
            end
            Gb1: begin
                // A lone final vector has no partner: pad its upper half with zeros.
                beat_valid = (state == StRun) && (lone || rdata_vld);
                beat_data  = lone ? {32'h0, hold} : {rdata[31:0], hold};
                beat_last  = lone;
                if (beat_accept) gb_next = lone ? Gb0 : Gb2;
            end
            Gb2: begin
                beat_valid = (state == StRun) && rdata_vld;
                beat_data  = rdata[95:32];
                beat_last  = last_vec;
                if (beat_accept) begin
                    consume = 1'b1;
                    gb_next = Gb0;
                end
            end
            default: gb_next = Gb0;
        endcase

        if (state == StIdle) gb_next = Gb0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= StIdle;
            gb            <= Gb0;
            bank_sel      <= 1'b0;
            wr_ptr        <= '0;
            drain_len     <= '0;
            rd_ptr        <= '0;
            vec_idx       <= '0;
            rdata_vld     <= 1'b0;
            hold          <= '0;
            lone          <= 1'b0;
            o_wr_overflow <= 1'b0;
            o_drain_done  <= 1'b0;
        end else begin
            state        <= state_next;
            gb           <= gb_next;
            o_drain_done <= tlast_hs;

            if (swap_accept) begin
                drain_len     <= new_len;
                bank_sel      <= ~bank_sel;
                wr_ptr        <= '0;
                o_wr_overflow <= 1'b0;
                rd_ptr        <= '0;
                vec_idx       <= '0;
            end else begin
                if (wr_accept) wr_ptr <= wr_ptr + PtrW'(1);
                if (i_wr_en && full) o_wr_overflow <= 1'b1;
                if (rd_en) rd_ptr <= rd_ptr + PtrW'(1);
                if (consume) vec_idx <= vec_idx + PtrW'(1);
            end

            if (rd_en) begin
                rdata_vld <= 1'b1;
            end else if (consume) begin
                rdata_vld <= 1'b0;
            end

            if (beat_accept && gb == Gb0) begin
                hold <= rdata[95:64];
                lone <= last_vec;
            end
        end
    end

    // Simple dual-port RAM with registered read; no reset so it maps to block RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) ram[{bank_sel, wr_ptr[DEPTH_LOG2-1:0]}] <= i_array_vec;
        if (rd_en) rdata <= ram[{~bank_sel, rd_ptr[DEPTH_LOG2-1:0]}];
    end

    axis_skid_buffer #(
        .W(AXIS_W + 1)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_data  ({beat_last, beat_data}),
        .in_valid (beat_valid),
        .in_ready (skid_ready),
        .out_data ({m_axis_tlast, m_axis_tdata}),
        .out_valid(m_axis_tvalid),
        .out_ready(m_axis_tready)
    );

endmodule

// File: tb/tb_output_buffer_ctrl.sv
// Directed bench for output_buffer_ctrl. Expected beats come from treating the
// written vectors as one little-endian bit stream cut into 64-bit beats.
module tb_output_buffer_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_wr_en;
    logic [95:0] i_array_vec;
    logic        i_bank_swap;
    logic        o_swap_ready;
    logic        o_wr_overflow;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        o_drain_done;

    int checks = 0;
    int errors = 0;
    logic [95:0] exp_vecs[$];
    logic [63:0] got[$];

    always #5 clk = ~clk;

    output_buffer_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .i_wr_en      (i_wr_en),
        .i_array_vec  (i_array_vec),
        .i_bank_swap  (i_bank_swap),
        .o_swap_ready (o_swap_ready),
        .o_wr_overflow(o_wr_overflow),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .o_drain_done (o_drain_done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [95:0] v);
        i_wr_en     = 1'b1;
        i_array_vec = v;
        tick();
        i_wr_en     = 1'b0;
    endtask

    task automatic do_swap();
        i_bank_swap = 1'b1;
        tick();
        i_bank_swap = 1'b0;
    endtask

    function automatic logic [95:0] mkvec(input int unsigned s);
        return {s * 32'h9E37_79B1, s ^ 32'hA5A5_A5A5, s + 32'h0101_0000};
    endfunction

    function automatic logic [63:0] exp_beat(input int k);
        logic [63:0] r;
        logic [95:0] v;
        int pos;
        int vi;
        r = '0;
        for (int b = 0; b < 64; b++) begin
            pos = 64 * k + b;
            vi  = pos / 96;
            if (vi < exp_vecs.size()) begin
                v    = exp_vecs[vi];
                r[b] = v[pos % 96];
            end
        end
        return r;
    endfunction

    // Called with the sample point at T+1 (one cycle after the accepted swap).
    task automatic drain(input string tag, input bit rnd, input int first_exp,
                         input bit mid_wr, input logic [95:0] w0, input logic [95:0] w1,
                         input int swap_at);
        int beats, k, cyc, first, dones;
        logic [63:0] pd;
        logic pl;
        bit stall;
        beats = (3 * exp_vecs.size() + 1) / 2;
        k = 0; cyc = 1; first = -1; dones = 0; stall = 0; pd = '0; pl = 1'b0;
        got.delete();
        while (dones == 0 && cyc < 3000) begin
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            i_wr_en       = mid_wr && (cyc == 2 || cyc == 3);
            i_array_vec   = (cyc == 2) ? w0 : w1;
            i_bank_swap   = (cyc == swap_at);
            if (cyc == 1) check({tag, "_swap_ready_low"}, 64'(o_swap_ready), 64'd0);
            if (stall) begin
                check({tag, "_stall_tvalid"}, 64'(m_axis_tvalid), 64'd1);
                check({tag, "_stall_tdata"}, m_axis_tdata, pd);
                check({tag, "_stall_tlast"}, 64'(m_axis_tlast), 64'(pl));
            end
            if (m_axis_tvalid && first < 0) first = cyc;
            if (o_drain_done) begin
                dones++;
                check({tag, "_ready_at_done"}, 64'(o_swap_ready), 64'd1);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                check({tag, "_tdata"}, m_axis_tdata, exp_beat(k));
                check({tag, "_tlast"}, 64'(m_axis_tlast), 64'(k == beats - 1));
                if (k == beats - 1) check({tag, "_ready_at_last"}, 64'(o_swap_ready), 64'd0);
                got.push_back(m_axis_tdata);
                k++;
            end
            stall = m_axis_tvalid && !m_axis_tready;
            pd    = m_axis_tdata;
            pl    = m_axis_tlast;
            tick();
            cyc++;
        end
        i_wr_en = 1'b0; i_bank_swap = 1'b0; m_axis_tready = 1'b1;
        check({tag, "_beat_count"}, 64'(k), 64'(beats));
        check({tag, "_done_pulse"}, 64'(dones), 64'd1);
        if (first_exp >= 0) check({tag, "_first_valid_cycle"}, 64'(first), 64'(first_exp));
        check({tag, "_done_one_cycle"}, 64'(o_drain_done), 64'd0);
        check({tag, "_idle_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    endtask

    initial begin
        logic [95:0] v;
        rst = 1'b1; i_wr_en = 1'b0; i_array_vec = '0; i_bank_swap = 1'b0;
        m_axis_tready = 1'b1;
        tick(); tick();
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_tdata", m_axis_tdata, 64'd0);
        check("rst_swap_ready", 64'(o_swap_ready), 64'd1);
        check("rst_overflow", 64'(o_wr_overflow), 64'd0);
        check("rst_drain_done", 64'(o_drain_done), 64'd0);
        rst = 1'b0;
        tick();

        // Two-vector pair: exact gearbox mapping and T+3 latency.
        exp_vecs.delete();
        exp_vecs.push_back(96'h0B0A_0908_0706_0504_0302_0100);
        exp_vecs.push_back(96'h1B1A_1918_1716_1514_1312_1110);
        wr(exp_vecs[0]); wr(exp_vecs[1]);
        do_swap();
        drain("pair", 1'b0, 3, 1'b0, '0, '0, -1);
        check("pair_beat0", got[0], 64'h0706_0504_0302_0100);
        check("pair_beat1", got[1], 64'h1312_1110_0B0A_0908);
        check("pair_beat2", got[2], 64'h1B1A_1918_1716_1514);

        // Odd count: lone last vector zero-padded.
        exp_vecs.delete();
        exp_vecs.push_back(96'h0B0A_0908_0706_0504_0302_0100);
        exp_vecs.push_back(96'h1B1A_1918_1716_1514_1312_1110);
        exp_vecs.push_back(96'h2B2A_2928_2726_2524_2322_2120);
        for (int i = 0; i < 3; i++) wr(exp_vecs[i]);
        do_swap();
        drain("odd3", 1'b0, 3, 1'b0, '0, '0, -1);
        check("odd3_beat3", got[3], 64'h2726_2524_2322_2120);
        check("odd3_beat4", got[4], 64'h0000_0000_2B2A_2928);

        // Full bank plus one dropped write.
        exp_vecs.delete();
        for (int i = 0; i < 256; i++) begin
            v = mkvec(i);
            exp_vecs.push_back(v);
            wr(v);
        end
        check("full_no_overflow", 64'(o_wr_overflow), 64'd0);
        wr(mkvec(32'hFFFF));
        check("overflow_set", 64'(o_wr_overflow), 64'd1);
        do_swap();
        check("overflow_cleared", 64'(o_wr_overflow), 64'd0);
        drain("full", 1'b0, 3, 1'b0, '0, '0, -1);

        // Random backpressure over 200 vectors.
        exp_vecs.delete();
        for (int i = 0; i < 200; i++) begin
            v = mkvec(1000 + i);
            exp_vecs.push_back(v);
            wr(v);
        end
        do_swap();
        drain("rnd200", 1'b1, -1, 1'b0, '0, '0, -1);

        // Swap while busy is ignored; concurrent writes go to the new bank.
        exp_vecs.delete();
        for (int i = 0; i < 3; i++) begin
            v = mkvec(2000 + i);
            exp_vecs.push_back(v);
            wr(v);
        end
        do_swap();
        drain("busy_swap", 1'b0, 3, 1'b1, mkvec(3000), mkvec(3001), 5);
        exp_vecs.delete();
        exp_vecs.push_back(mkvec(3000));
        exp_vecs.push_back(mkvec(3001));
        do_swap();
        drain("after_busy", 1'b0, 3, 1'b0, '0, '0, -1);

        // Empty swap emits nothing.
        do_swap();
        for (int i = 0; i < 6; i++) begin
            check("empty_tvalid", 64'(m_axis_tvalid), 64'd0);
            check("empty_swap_ready", 64'(o_swap_ready), 64'd1);
            tick();
        end

        // Reset mid-drain, then a clean pair drain.
        wr(mkvec(4000)); wr(mkvec(4001));
        m_axis_tready = 1'b0;
        do_swap();
        for (int i = 0; i < 10 && !m_axis_tvalid; i++) tick();
        check("mid_tvalid_before_rst", 64'(m_axis_tvalid), 64'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("mid_rst_swap_ready", 64'(o_swap_ready), 64'd1);
        rst = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        exp_vecs.delete();
        exp_vecs.push_back(mkvec(5000));
        exp_vecs.push_back(mkvec(5001));
        wr(exp_vecs[0]); wr(exp_vecs[1]);
        do_swap();
        drain("post_rst", 1'b0, 3, 1'b0, '0, '0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
